// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall / flush / freeze / halt-drain control for the
//                    ID/EX consumer side, with stall and redirect counters.
// Optional macro    : HAZ_FWD_EN (EX/MEM forwarding present; only load-use stalls)
// Revision          : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_halt,
  input  logic [2:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [2:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_redirect,
  input  logic             dmem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              C_DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [C_DW-1:0] C_DRAIN_LOAD = C_DW'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_DRAIN   = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [C_DW-1:0]   r_drain_cnt;
  logic [C_DW-1:0]   w_drain_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_match_ex;
  logic              w_match_mem;
  logic              w_hz;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_match_ex  = ex_reg_write & id_valid &
                       ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  assign w_match_mem = mem_reg_write & id_valid &
                       ((id_use_rs & (id_rs == mem_rd)) | (id_use_rt & (id_rt == mem_rd)));

`ifdef HAZ_FWD_EN
  logic w_unused_mem_match;
  assign w_unused_mem_match = w_match_mem;
  assign w_hz = w_match_ex & ex_mem_read;
`else
  logic w_unused_mem_read;
  assign w_unused_mem_read = ex_mem_read;
  assign w_hz = w_match_ex | w_match_mem;
`endif

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    halted      = 1'b0;
    w_next      = r_state;
    w_drain_nxt = r_drain_cnt;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (rst) begin
      case (r_state)
        S_RUN, S_MEMWAIT: begin
          // MEMWAIT exit cycle is evaluated exactly like RUN
          if (!(r_state == S_MEMWAIT && dmem_stall)) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            w_next   = S_RUN;
            if (dmem_stall) begin
              pc_en    = 1'b0;
              ifid_en  = 1'b0;
              idex_en  = 1'b0;
              exmem_en = 1'b0;
              w_next   = S_MEMWAIT;
            end else if (ex_redirect) begin
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              w_flush_inc = 1'b1;
            end else if (w_hz) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_flush  = 1'b1;
              w_stall_inc = 1'b1;
            end else if (id_halt && id_valid) begin
              pc_en       = 1'b0;
              ifid_flush  = 1'b1;
              w_drain_nxt = C_DRAIN_LOAD;
              w_next      = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = ~dmem_stall;
          if (!dmem_stall) begin
            if (r_drain_cnt == '0) w_next = S_HALTED;
            else                   w_drain_nxt = r_drain_cnt - C_DW'(1);
          end
        end
        S_HALTED: halted = 1'b1;
        default:  w_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_nxt;
      if (w_stall_inc && (r_stall_cnt != C_CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != C_CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
